// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined WIDTH-bit ALU with flags, accumulator and
// valid/ready handshakes. Stage 1 captures operands; stage 2 computes and
// holds the result. Every opcode maps onto one (WIDTH+1)-bit adder.
module alu_pipe #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic [WIDTH-1:0] acc
);

   typedef enum logic [2:0] {
      OpAdd  = 3'b000,
      OpPass = 3'b001,
      OpDec  = 3'b010,
      OpSubb = 3'b011,
      OpAddc = 3'b100,
      OpInc  = 3'b101,
      OpNeg  = 3'b110,
      OpAcc  = 3'b111
   } op_e;

   localparam int unsigned Msb = WIDTH - 1;

   // Pipeline control
   logic adv;
   logic in_xfer;

   // Stage 1: captured operands
   logic             s1_valid_q;
   op_e              s1_sel_q;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   logic             s1_clr_q;

   // Compute datapath
   logic [WIDTH-1:0] acc_eff;
   logic [WIDTH-1:0] op_x;
   logic [WIDTH-1:0] op_y;
   logic             op_cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sum_res;
   logic [3:0]       flags_d;
   logic [WIDTH-1:0] acc_d;

   // Stage 2: presented result
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;
   logic [WIDTH-1:0] acc_q;

   // The whole pipe moves together whenever the output slot is free or draining.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv && !rst;
   assign in_xfer  = in_valid && in_ready;

   // Stage 1 register: capture opcode/operands, bubble when nothing is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_sel_q   <= OpAdd;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_clr_q   <= 1'b0;
      end else if (adv) begin
         s1_valid_q <= in_xfer;
         s1_sel_q   <= op_e'(alu_sel);
         s1_a_q     <= a;
         s1_b_q     <= b;
         s1_clr_q   <= acc_clr;
      end
   end

   // Opcode decode into adder operands; clear takes effect before accumulate.
   always_comb begin
      acc_eff = s1_clr_q ? '0 : acc_q;
      op_x    = '0;
      op_y    = '0;
      op_cin  = 1'b0;
      unique case (s1_sel_q)
         OpAdd: begin
            op_x = s1_a_q;
            op_y = s1_b_q;
         end
         OpPass: begin
            op_x = s1_a_q;
         end
         OpDec: begin
            op_x = s1_b_q;
            op_y = '1;
         end
         OpSubb: begin
            op_x = s1_a_q;
            op_y = ~s1_b_q;
         end
         OpAddc: begin
            op_x   = s1_a_q;
            op_y   = s1_b_q;
            op_cin = 1'b1;
         end
         OpInc: begin
            op_x   = s1_a_q;
            op_cin = 1'b1;
         end
         OpNeg: begin
            op_x   = ~s1_b_q;
            op_cin = 1'b1;
         end
         OpAcc: begin
            op_x = acc_eff;
            op_y = s1_a_q;
         end
         default: begin
            op_x = '0;
         end
      endcase
   end

   // Single shared adder, flags and next accumulator value.
   always_comb begin
      sum     = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, op_cin};
      sum_res = sum[WIDTH-1:0];
      flags_d = {sum_res[Msb],
                 (sum_res == '0),
                 sum[WIDTH],
                 (op_x[Msb] == op_y[Msb]) && (sum_res[Msb] != op_x[Msb])};
      acc_d   = acc_q;
      if (s1_sel_q == OpAcc) begin
         acc_d = sum_res;
      end else if (s1_clr_q) begin
         acc_d = '0;
      end
   end

   // Stage 2 register: bubbles drop out_valid but keep the last result/flags/acc.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         acc_q       <= '0;
      end else if (adv) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            result_q <= sum_res;
            flags_q  <= flags_d;
            acc_q    <= acc_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe at WIDTH=8 and WIDTH=16.
// Both instances share clock, reset and handshake controls.
module tb_alu_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        acc_clr;
   logic [2:0]  alu_sel;
   logic [7:0]  a8, b8, result8, acc8;
   logic [15:0] a16, b16, result16, acc16;
   logic [3:0]  flags8, flags16;
   logic        in_ready8, in_ready16, out_valid8, out_valid16;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int res;
      int flg;
      int acc;
   } item_t;

   item_t exp8[$];
   item_t obs8[$];
   item_t exp16[$];
   item_t obs16[$];
   int    macc8  = 0;
   int    macc16 = 0;

   alu_pipe #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready8),
      .alu_sel   (alu_sel),
      .a         (a8),
      .b         (b8),
      .acc_clr   (acc_clr),
      .out_valid (out_valid8),
      .out_ready (out_ready),
      .result    (result8),
      .flags     (flags8),
      .acc       (acc8)
   );

   alu_pipe #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready16),
      .alu_sel   (alu_sel),
      .a         (a16),
      .b         (b16),
      .acc_clr   (acc_clr),
      .out_valid (out_valid16),
      .out_ready (out_ready),
      .result    (result16),
      .flags     (flags16),
      .acc       (acc16)
   );

   // Reference model: operands per opcode, then add and derive flags/acc.
   function automatic item_t model(int w, logic [2:0] sel, int av, int bv, bit clr, int accv);
      item_t  it;
      int     mask, x, y, cin, r, xm, ym, rm;
      longint s;
      mask = (1 << w) - 1;
      x = 0;
      y = 0;
      cin = 0;
      case (sel)
         3'd0: begin x = av; y = bv; end
         3'd1: x = av;
         3'd2: begin x = bv; y = mask; end
         3'd3: begin x = av; y = ~bv & mask; end
         3'd4: begin x = av; y = bv; cin = 1; end
         3'd5: begin x = av; cin = 1; end
         3'd6: begin x = ~bv & mask; cin = 1; end
         default: begin x = clr ? 0 : accv; y = av; end
      endcase
      s  = longint'(x) + longint'(y) + longint'(cin);
      r  = int'(s) & mask;
      xm = (x >> (w - 1)) & 1;
      ym = (y >> (w - 1)) & 1;
      rm = (r >> (w - 1)) & 1;
      it.res = r;
      it.flg = (rm << 3) | ((r == 0) ? 4 : 0) | ((((s >> w) & 1) != 0) ? 2 : 0)
             | (((xm == ym) && (rm != xm)) ? 1 : 0);
      if (sel == 3'd7) it.acc = r;
      else if (clr)    it.acc = 0;
      else             it.acc = accv;
      return it;
   endfunction

   // One clock: log presented results, push expectations for accepted inputs.
   task automatic tick();
      item_t it;
      #1;
      if (out_valid8 && out_ready) begin
         it.res = int'(result8); it.flg = int'(flags8); it.acc = int'(acc8);
         obs8.push_back(it);
      end
      if (out_valid16 && out_ready) begin
         it.res = int'(result16); it.flg = int'(flags16); it.acc = int'(acc16);
         obs16.push_back(it);
      end
      if (in_valid && in_ready8) begin
         it = model(8, alu_sel, int'(a8), int'(b8), acc_clr, macc8);
         macc8 = it.acc;
         exp8.push_back(it);
      end
      if (in_valid && in_ready16) begin
         it = model(16, alu_sel, int'(a16), int'(b16), acc_clr, macc16);
         macc16 = it.acc;
         exp16.push_back(it);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0; alu_sel = 3'd0;
      a8 = '0; b8 = '0; a16 = '0; b16 = '0;
      @(negedge clk);
      #1;
      checks++; if (in_ready8 !== 1'b0) begin failures++;
         $display("FAIL rst_in_ready got=%0h exp=0", in_ready8); end
      checks++; if (out_valid8 !== 1'b0) begin failures++;
         $display("FAIL rst_out_valid got=%0h exp=0", out_valid8); end
      checks++; if (result8 !== 8'h00) begin failures++;
         $display("FAIL rst_result got=%0h exp=0", result8); end
      checks++; if (flags8 !== 4'h0) begin failures++;
         $display("FAIL rst_flags got=%0h exp=0", flags8); end
      checks++; if (acc8 !== 8'h00) begin failures++;
         $display("FAIL rst_acc got=%0h exp=0", acc8); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (in_ready8 !== 1'b1) begin failures++;
         $display("FAIL rst_release_in_ready got=%0h exp=1", in_ready8); end
      @(negedge clk);
   endtask

   task automatic test_basic_ops();
      logic [2:0] ts[8];
      logic [7:0] ta[8], tb[8], tr[8];
      logic [3:0] tf[8];
      ts = '{3'd0, 3'd0, 3'd3, 3'd6, 3'd2, 3'd1, 3'd5, 3'd4};
      ta = '{8'hFF, 8'h7F, 8'h05, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'h10};
      tb = '{8'h01, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
      tr = '{8'h00, 8'h80, 8'h01, 8'h00, 8'hFF, 8'h5A, 8'h00, 8'h31};
      tf = '{4'b0110, 4'b1001, 4'b0010, 4'b0110, 4'b1000, 4'b0000, 4'b0110, 4'b0000};
      out_ready = 1'b1;
      acc_clr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; alu_sel = ts[i]; a8 = ta[i]; b8 = tb[i];
         @(negedge clk);
         in_valid = 1'b0;
         checks++; if (out_valid8 !== 1'b0) begin failures++;
            $display("FAIL op%0d_early_valid got=%0h exp=0", i, out_valid8); end
         @(negedge clk);
         checks++; if (out_valid8 !== 1'b1) begin failures++;
            $display("FAIL op%0d_latency got=%0h exp=1", i, out_valid8); end
         checks++; if (result8 !== tr[i]) begin failures++;
            $display("FAIL op%0d_result got=%0h exp=%0h", i, result8, tr[i]); end
         checks++; if (flags8 !== tf[i]) begin failures++;
            $display("FAIL op%0d_flags got=%0h exp=%0h", i, flags8, tf[i]); end
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_acc();
      logic [2:0] ts[4];
      logic [7:0] ta[4], tr[4], tac[4];
      logic [3:0] tf[4];
      logic       tc[4];
      ts  = '{3'd7, 3'd7, 3'd7, 3'd1};
      ta  = '{8'h80, 8'h80, 8'h03, 8'h11};
      tc  = '{1'b1, 1'b0, 1'b1, 1'b1};
      tr  = '{8'h80, 8'h00, 8'h03, 8'h11};
      tf  = '{4'b1000, 4'b0111, 4'b0000, 4'b0000};
      tac = '{8'h80, 8'h00, 8'h03, 8'h00};
      out_ready = 1'b1;
      b8 = 8'h00;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            in_valid = 1'b1; alu_sel = ts[i]; a8 = ta[i]; acc_clr = tc[i];
         end else begin
            in_valid = 1'b0; acc_clr = 1'b0;
         end
         @(negedge clk);
         if (i >= 1) begin
            checks++; if (out_valid8 !== 1'b1) begin failures++;
               $display("FAIL acc%0d_valid got=%0h exp=1", i - 1, out_valid8); end
            checks++; if (result8 !== tr[i-1]) begin failures++;
               $display("FAIL acc%0d_result got=%0h exp=%0h", i - 1, result8, tr[i-1]); end
            checks++; if (flags8 !== tf[i-1]) begin failures++;
               $display("FAIL acc%0d_flags got=%0h exp=%0h", i - 1, flags8, tf[i-1]); end
            checks++; if (acc8 !== tac[i-1]) begin failures++;
               $display("FAIL acc%0d_acc got=%0h exp=%0h", i - 1, acc8, tac[i-1]); end
         end
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int         idx = 0;
      int         n;
      logic [7:0] snap_r;
      logic [3:0] snap_f;
      item_t      e, o;
      acc_clr = 1'b0;
      for (int i = 0; i < 12; i++) begin
         in_valid  = (idx < 6);
         alu_sel   = 3'(idx % 7);
         a8        = 8'(idx * 37 + 11);
         b8        = 8'(idx * 53 + 5);
         out_ready = !(i >= 3 && i < 6);
         #1;
         if (i == 3) begin
            snap_r = result8; snap_f = flags8;
            checks++; if (out_valid8 !== 1'b1) begin failures++;
               $display("FAIL b2b_full got=%0h exp=1", out_valid8); end
         end
         if (i >= 3 && i < 6) begin
            checks++; if (in_ready8 !== 1'b0) begin failures++;
               $display("FAIL b2b_stall_in_ready c%0d got=%0h exp=0", i, in_ready8); end
         end
         if (i == 4 || i == 5) begin
            checks++; if (result8 !== snap_r) begin failures++;
               $display("FAIL b2b_hold_result c%0d got=%0h exp=%0h", i, result8, snap_r); end
            checks++; if (flags8 !== snap_f) begin failures++;
               $display("FAIL b2b_hold_flags c%0d got=%0h exp=%0h", i, flags8, snap_f); end
         end
         n = exp8.size();
         tick();
         if (exp8.size() != n) idx++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();
      checks++; if (obs8.size() != 6 || exp8.size() != 6) begin failures++;
         $display("FAIL b2b_count got=%0d exp=%0d", obs8.size(), exp8.size()); end
      while (obs8.size() > 0 && exp8.size() > 0) begin
         o = obs8.pop_front(); e = exp8.pop_front();
         checks++; if (o.res !== e.res || o.flg !== e.flg || o.acc !== e.acc) begin failures++;
            $display("FAIL b2b_item got=%0h/%0h/%0h exp=%0h/%0h/%0h",
                     o.res, o.flg, o.acc, e.res, e.flg, e.acc); end
      end
      exp8.delete(); obs8.delete(); exp16.delete(); obs16.delete();
   endtask

   task automatic test_reset_midstream();
      bit seen = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1; alu_sel = 3'd7; a8 = 8'h05; acc_clr = 1'b1;
      @(negedge clk);
      alu_sel = 3'd0; a8 = 8'h01; b8 = 8'h02; acc_clr = 1'b0;
      @(posedge clk);
      in_valid = 1'b0;
      #2;
      checks++; if (acc8 !== 8'h05 || out_valid8 !== 1'b1) begin failures++;
         $display("FAIL mid_pre got=%0h/%0h exp=5/1", acc8, out_valid8); end
      rst = 1'b1;
      #1;
      checks++; if (out_valid8 !== 1'b0) begin failures++;
         $display("FAIL mid_out_valid got=%0h exp=0", out_valid8); end
      checks++; if (result8 !== 8'h00 || flags8 !== 4'h0) begin failures++;
         $display("FAIL mid_result_flags got=%0h/%0h exp=0/0", result8, flags8); end
      checks++; if (acc8 !== 8'h00) begin failures++;
         $display("FAIL mid_acc got=%0h exp=0", acc8); end
      checks++; if (in_ready8 !== 1'b0) begin failures++;
         $display("FAIL mid_in_ready got=%0h exp=0", in_ready8); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid8) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++;
         $display("FAIL mid_ghost got=%0h exp=0", seen); end
      in_valid = 1'b1; alu_sel = 3'd0; a8 = 8'h02; b8 = 8'h03;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid8 !== 1'b0) begin failures++;
         $display("FAIL mid_next_early got=%0h exp=0", out_valid8); end
      @(negedge clk);
      checks++; if (out_valid8 !== 1'b1 || result8 !== 8'h05) begin failures++;
         $display("FAIL mid_next got=%0h/%0h exp=1/5", out_valid8, result8); end
      @(negedge clk);
   endtask

   task automatic test_random();
      item_t e, o;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp8.delete(); obs8.delete(); exp16.delete(); obs16.delete();
      macc8 = 0; macc16 = 0;
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         alu_sel   = 3'($urandom_range(0, 7));
         acc_clr   = ($urandom_range(0, 7) == 0);
         a8  = 8'($urandom);  b8  = 8'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) tick();
      checks++; if (obs8.size() != exp8.size() || exp8.size() == 0) begin failures++;
         $display("FAIL rnd8_count got=%0d exp=%0d", obs8.size(), exp8.size()); end
      checks++; if (obs16.size() != exp16.size() || exp16.size() == 0) begin failures++;
         $display("FAIL rnd16_count got=%0d exp=%0d", obs16.size(), exp16.size()); end
      while (obs8.size() > 0 && exp8.size() > 0) begin
         o = obs8.pop_front(); e = exp8.pop_front();
         checks++; if (o.res !== e.res || o.flg !== e.flg || o.acc !== e.acc) begin failures++;
            $display("FAIL rnd8_item got=%0h/%0h/%0h exp=%0h/%0h/%0h",
                     o.res, o.flg, o.acc, e.res, e.flg, e.acc); end
      end
      while (obs16.size() > 0 && exp16.size() > 0) begin
         o = obs16.pop_front(); e = exp16.pop_front();
         checks++; if (o.res !== e.res || o.flg !== e.flg || o.acc !== e.acc) begin failures++;
            $display("FAIL rnd16_item got=%0h/%0h/%0h exp=%0h/%0h/%0h",
                     o.res, o.flg, o.acc, e.res, e.flg, e.acc); end
      end
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_basic_ops();
      test_acc();
      test_back_to_back();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
